// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the load/store unit: access-size encodings,
//   FSM state encoding and the alignment check used at request accept.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LD   = 3'd2,
        ST_MRG  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } mau_state_t;

    // True when the access cannot be performed with a single word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_access_unit_lane
//   Purely combinational lane logic for the load/store unit.
//   Ports:
//     size      in  2   access size (SIZE_*)
//     zero_ext  in  1   1 = zero-extend loads, 0 = sign-extend
//     byte_off  in  2   byte offset within the word (little-endian lanes)
//     rd_word   in  32  word read from data memory
//     st_data   in  32  right-justified store data
//     ld_ext    out 32  selected lane, extended to 32 bits
//     merged    out 32  rd_word with the selected lane replaced by st_data
module mem_access_unit_lane
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (byte_off)
            2'd0:    byte_v = rd_word[7:0];
            2'd1:    byte_v = rd_word[15:8];
            2'd2:    byte_v = rd_word[23:16];
            default: byte_v = rd_word[31:24];
        endcase
        half_v = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        ld_ext = rd_word;
        case (size)
            SIZE_BYTE: ld_ext = {{24{~zero_ext & byte_v[7]}}, byte_v};
            SIZE_HALF: ld_ext = {{16{~zero_ext & half_v[15]}}, half_v};
            default:   ld_ext = rd_word;
        endcase
    end

    always_comb begin
        merged = rd_word;
        case (size)
            SIZE_BYTE: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = st_data[7:0];
                    2'd1:    merged[15:8]  = st_data[7:0];
                    2'd2:    merged[23:16] = st_data[7:0];
                    default: merged[31:24] = st_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (byte_off[1])
                    merged[31:16] = st_data[15:0];
                else
                    merged[15:0] = st_data[15:0];
            end
            SIZE_WORD: merged = st_data;
            default:   merged = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between the execute stage and a word-wide data memory.
//   Byte/half/word loads and stores on a Req/Done handshake; sub-word stores
//   use read-modify-write, loads are sign- or zero-extended.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for Req; operands latched on accept
//   RD    | DmAd held with DmMemWr=0, memory returns the word next cycle
//   LD    | LdData captures the extended lane
//   MRG   | write back the read word with the lane replaced
//   WR    | aligned word store, StData written directly
//   DONE  | one-cycle Done pulse, Misalign valid
//
//   Ports:
//     Clk, Reset (async, active-low)
//     Req, Wr, Size, Unsigned, Addr, StData   request from the CPU
//     Busy, Done, LdData, Misalign            status/result to the CPU
//     DmAd, DmWrData, DmMemWr, DmRdData       data memory interface
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] LdData,
    output logic        Misalign,
    output logic [29:0] DmAd,
    output logic [31:0] DmWrData,
    output logic        DmMemWr,
    input  logic [31:0] DmRdData
);

    mau_state_t  state_q, state_d;
    logic [31:0] addr_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] st_q;
    logic [31:0] ld_q;
    logic        mis_q;
    logic [31:0] ld_ext;
    logic [31:0] merged;
    logic        accept;

    assign accept = (state_q == ST_IDLE) && Req;

    mem_access_unit_lane u_lane (
        .size     (size_q),
        .zero_ext (uns_q),
        .byte_off (addr_q[1:0]),
        .rd_word  (DmRdData),
        .st_data  (st_q),
        .ld_ext   (ld_ext),
        .merged   (merged)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            st_q    <= 32'h0;
            ld_q    <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= Addr;
                wr_q   <= Wr;
                size_q <= Size;
                uns_q  <= Unsigned;
                st_q   <= StData;
                mis_q  <= is_misaligned(Size, Addr[1:0]);
            end
            if (state_q == ST_LD)
                ld_q <= ld_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    if (is_misaligned(Size, Addr[1:0]))
                        state_d = ST_DONE;
                    else if (Wr && (Size == SIZE_WORD))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = wr_q ? ST_MRG : ST_LD;
            ST_LD:   state_d = ST_DONE;
            ST_MRG:  state_d = ST_DONE;
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write strobe and data decode straight from the state register so an
    // asynchronous reset removes them without waiting for a clock edge.
    always_comb begin
        DmMemWr  = 1'b0;
        DmWrData = 32'h0;
        case (state_q)
            ST_MRG: begin
                DmMemWr  = 1'b1;
                DmWrData = merged;
            end
            ST_WR: begin
                DmMemWr  = 1'b1;
                DmWrData = st_q;
            end
            default: begin
                DmMemWr  = 1'b0;
                DmWrData = 32'h0;
            end
        endcase
    end

    assign Busy     = (state_q != ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign LdData   = ld_q;
    assign Misalign = mis_q;
    assign DmAd     = addr_q[31:2];

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        Wr;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] StData;
    logic        Busy;
    logic        Done;
    logic [31:0] LdData;
    logic        Misalign;
    logic [29:0] DmAd;
    logic [31:0] DmWrData;
    logic        DmMemWr;
    logic [31:0] DmRdData;

    logic [31:0] mem [64];

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mem_access_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Wr       (Wr),
        .Size     (Size),
        .Unsigned (Unsigned),
        .Addr     (Addr),
        .StData   (StData),
        .Busy     (Busy),
        .Done     (Done),
        .LdData   (LdData),
        .Misalign (Misalign),
        .DmAd     (DmAd),
        .DmWrData (DmWrData),
        .DmMemWr  (DmMemWr),
        .DmRdData (DmRdData)
    );

    // Synchronous-read data memory model
    always @(posedge Clk) begin
        if (DmMemWr)
            mem[DmAd[5:0]] <= DmWrData;
        DmRdData <= mem[DmAd[5:0]];
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] init;
        int          exp_done;
        int          exp_wr_cyc;
        logic        exp_mis;
        logic [31:0] exp_ld;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge and observe cycles 1.. after the accept edge.
    task automatic do_op(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] st, input logic hold,
                         output int done_cyc, output int wr_cnt, output int wr_cyc);
        done_cyc = 0;
        wr_cnt   = 0;
        wr_cyc   = 0;
        @(negedge Clk);
        Req = 1'b1; Wr = wr; Size = size; Unsigned = uns; Addr = addr; StData = st;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge Clk);
            if (!hold) Req = 1'b0;
            if (DmMemWr) begin
                wr_cnt++;
                if (wr_cyc == 0) wr_cyc = cyc;
            end
            if (Done) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int dc, wc, wcy, dpulses, wpulses;
        logic busy4, busy5;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        Reset = 1'b0; Req = 1'b0; Wr = 1'b0; Size = 2'b00; Unsigned = 1'b0;
        Addr = 32'h0; StData = 32'h0;

        //           wr    size   uns   addr      st            init          done wcy mis   exp_ld        exp_mem
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 2, 1, 1'b0, 32'h00000000, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h80FF1234, 3, 0, 1'b0, 32'hFFFFFF80, 32'h80FF1234};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h80FF1234, 3, 0, 1'b0, 32'h00000080, 32'h80FF1234};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 32'h11223344, 3, 2, 1'b0, 32'h00000080, 32'hABCD3344};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'h55667788, 1, 0, 1'b1, 32'h00000080, 32'h55667788};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h16, 32'h0,        32'h01020304, 1, 0, 1'b1, 32'h00000080, 32'h01020304};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h80017FFF, 3, 0, 1'b0, 32'hFFFF8001, 32'h80017FFF};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h80017FFF, 3, 0, 1'b0, 32'h00007FFF, 32'h80017FFF};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAA, 32'h11223344, 3, 2, 1'b0, 32'h00007FFF, 32'h1122AA44};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 3, 0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 2'b11, 1'b0, 32'h50, 32'h12345678, 32'h0000007F, 1, 0, 1'b1, 32'hCAFEF00D, 32'h0000007F};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h50, 32'h0,        32'h0000007F, 3, 0, 1'b0, 32'h0000007F, 32'h0000007F};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h00, 32'h12345678, 32'hFFFFFFFF, 3, 2, 1'b0, 32'h0000007F, 32'hFFFFFF78};

        repeat (3) @(negedge Clk);
        chk("reset_busy",     {31'h0, Busy},     32'h0);
        chk("reset_done",     {31'h0, Done},     32'h0);
        chk("reset_memwr",    {31'h0, DmMemWr},  32'h0);
        chk("reset_misalign", {31'h0, Misalign}, 32'h0);
        chk("reset_lddata",   LdData,            32'h0);
        chk("reset_dmad",     {2'b00, DmAd},     32'h0);
        chk("reset_wrdata",   DmWrData,          32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        for (int v = 0; v < 13; v++) begin
            mem[vecs[v].addr[7:2]] = vecs[v].init;
            do_op(vecs[v].wr, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].st, 1'b0, dc, wc, wcy);
            chk($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done);
            chk($sformatf("v%0d_write_pulses", v), wc, (vecs[v].exp_wr_cyc != 0) ? 1 : 0);
            chk($sformatf("v%0d_write_cycle", v), wcy, vecs[v].exp_wr_cyc);
            chk($sformatf("v%0d_misalign", v), {31'h0, Misalign}, {31'h0, vecs[v].exp_mis});
            chk($sformatf("v%0d_lddata", v), LdData, vecs[v].exp_ld);
            chk($sformatf("v%0d_dmad", v), {2'b00, DmAd}, {2'b00, vecs[v].addr[31:2]});
            chk($sformatf("v%0d_mem", v), mem[vecs[v].addr[7:2]], vecs[v].exp_mem);
        end

        // Req held high through a byte store: one op, then re-accept right after DONE
        mem[24] = 32'h0;
        dpulses = 0; wpulses = 0; busy4 = 1'b0; busy5 = 1'b0;
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; Size = 2'b00; Unsigned = 1'b0; Addr = 32'h61; StData = 32'h000000EE;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge Clk);
            if (cyc <= 4 && Done) dpulses++;
            if (cyc <= 4 && DmMemWr) wpulses++;
            if (cyc == 4) busy4 = Busy;
            if (cyc == 5) busy5 = Busy;
        end
        Req = 1'b0;
        chk("hold_done_pulses",  dpulses, 1);
        chk("hold_write_pulses", wpulses, 1);
        chk("hold_idle_after_done", {31'h0, busy4}, 32'h0);
        chk("hold_reaccept",     {31'h0, busy5}, 32'h1);
        chk("hold_mem",          mem[24], 32'h0000EE00);
        for (int i = 0; i < 10 && Busy; i++) @(negedge Clk);
        chk("hold_idle_timeout", {31'h0, Busy}, 32'h0);

        // Asynchronous reset during MRG
        mem[28] = 32'hAABBCCDD;
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; Size = 2'b00; Unsigned = 1'b0; Addr = 32'h70; StData = 32'h00000011;
        @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
        chk("rst_mrg_memwr_before", {31'h0, DmMemWr}, 32'h1);
        #1 Reset = 1'b0;
        #1;
        chk("rst_mrg_memwr_after", {31'h0, DmMemWr}, 32'h0);
        chk("rst_mrg_busy",        {31'h0, Busy},    32'h0);
        chk("rst_mrg_done",        {31'h0, Done},    32'h0);
        chk("rst_mrg_dmad",        {2'b00, DmAd},    32'h0);
        chk("rst_mrg_wrdata",      DmWrData,         32'h0);
        chk("rst_mrg_lddata",      LdData,           32'h0);
        chk("rst_mrg_misalign",    {31'h0, Misalign}, 32'h0);
        @(negedge Clk);
        chk("rst_mrg_mem_intact",  mem[28], 32'hAABBCCDD);
        Reset = 1'b1;
        @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
